// File: rtl/core_s2_operand_stage_pkg.sv
// Shared types and default configuration for the stage-2 operand front end.
package core_s2_operand_stage_pkg;

    localparam int unsigned CORE_XLEN      = 32;
    localparam int unsigned CORE_NUM_REGS  = 32;
    localparam int unsigned CORE_NUM_FWD   = 2;
    localparam int unsigned CORE_PAYLOAD_W = 64;
    localparam int unsigned CORE_SB_CNT_W  = 2;
    localparam int unsigned CORE_IDX_W     = $clog2(CORE_NUM_REGS);

    typedef logic [CORE_SB_CNT_W-1:0] sb_cnt_t;
    typedef logic [CORE_IDX_W-1:0]    reg_idx_t;

    typedef struct packed {
        logic [CORE_XLEN-1:0] rs1_val;
        logic [CORE_XLEN-1:0] rs2_val;
        reg_idx_t             rd_idx;
        logic                 rd_we;
    } s2_operands_t;

endpackage

// File: rtl/core_s2_operand_stage_if.sv
// s1/s3/bypass/writeback signal bundle of the stage-2 operand front end.
interface core_s2_operand_stage_if
    import core_s2_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN      = CORE_XLEN,
    parameter int unsigned NUM_REGS  = CORE_NUM_REGS,
    parameter int unsigned NUM_FWD   = CORE_NUM_FWD,
    parameter int unsigned PAYLOAD_W = CORE_PAYLOAD_W
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [IDX_W-1:0]          in_rs1_idx;
    logic [IDX_W-1:0]          in_rs2_idx;
    logic [IDX_W-1:0]          in_rd_idx;
    logic                      in_rd_we;
    logic [PAYLOAD_W-1:0]      in_payload;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           out_rs1_val;
    logic [XLEN-1:0]           out_rs2_val;
    logic [IDX_W-1:0]          out_rd_idx;
    logic                      out_rd_we;
    logic [PAYLOAD_W-1:0]      out_payload;
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD*IDX_W-1:0]  fwd_idx;
    logic [NUM_FWD*XLEN-1:0]   fwd_data;
    logic                      wb_valid;
    logic                      wb_we;
    logic [IDX_W-1:0]          wb_idx;
    logic [XLEN-1:0]           wb_data;
    logic                      sb_busy;

    modport slave (
        input  flush, in_valid, in_rs1_idx, in_rs2_idx, in_rd_idx, in_rd_we, in_payload,
        input  out_ready, fwd_valid, fwd_idx, fwd_data, wb_valid, wb_we, wb_idx, wb_data,
        output in_ready, out_valid, out_rs1_val, out_rs2_val, out_rd_idx, out_rd_we,
        output out_payload, sb_busy
    );

    modport master (
        output flush, in_valid, in_rs1_idx, in_rs2_idx, in_rd_idx, in_rd_we, in_payload,
        output out_ready, fwd_valid, fwd_idx, fwd_data, wb_valid, wb_we, wb_idx, wb_data,
        input  in_ready, out_valid, out_rs1_val, out_rs2_val, out_rd_idx, out_rd_we,
        input  out_payload, sb_busy
    );

endinterface

// File: rtl/core_s2_operand_stage_scoreboard.sv
// Per-register pending-write counters; x0 is never tracked.
module core_s2_operand_stage_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned SB_CNT_W = 2,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_inc_en,
    input  logic [IDX_W-1:0]    i_inc_idx,
    input  logic                i_dec_en,
    input  logic [IDX_W-1:0]    i_dec_idx,
    input  logic                i_fdec_en,
    input  logic [IDX_W-1:0]    i_fdec_idx,
    input  logic [IDX_W-1:0]    i_rs1_idx,
    input  logic [IDX_W-1:0]    i_rs2_idx,
    input  logic [IDX_W-1:0]    i_rd_idx,
    output logic [SB_CNT_W-1:0] o_rs1_cnt,
    output logic [SB_CNT_W-1:0] o_rs2_cnt,
    output logic [SB_CNT_W-1:0] o_rd_cnt,
    output logic                o_busy
);

    logic [SB_CNT_W-1:0] r_cnt      [NUM_REGS];
    logic [SB_CNT_W-1:0] w_cnt_next [NUM_REGS];
    logic                w_busy;

    // Simultaneous events on one register sum, so +1-1 nets to no change.
    always_comb begin
        w_busy = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_cnt_next[r] = r_cnt[r];
            if (r != 0) begin
                w_cnt_next[r] = r_cnt[r]
                              + SB_CNT_W'(i_inc_en  && (i_inc_idx  == IDX_W'(r)))
                              - SB_CNT_W'(i_dec_en  && (i_dec_idx  == IDX_W'(r)))
                              - SB_CNT_W'(i_fdec_en && (i_fdec_idx == IDX_W'(r)));
            end
            w_busy = w_busy | (r_cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= w_cnt_next[r];
            end
        end
    end

    assign o_rs1_cnt = r_cnt[i_rs1_idx];
    assign o_rs2_cnt = r_cnt[i_rs2_idx];
    assign o_rd_cnt  = r_cnt[i_rd_idx];
    assign o_busy    = w_busy;

    a_no_dec_of_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (i_dec_en && (i_dec_idx != '0)) |-> (r_cnt[i_dec_idx] != '0));

endmodule

// File: rtl/core_s2_operand_stage.sv
// Stage-2 operand front end: register file read, bypass resolution, scoreboard and s3 register.
module core_s2_operand_stage
    import core_s2_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN      = CORE_XLEN,
    parameter int unsigned NUM_REGS  = CORE_NUM_REGS,
    parameter int unsigned NUM_FWD   = CORE_NUM_FWD,
    parameter int unsigned PAYLOAD_W = CORE_PAYLOAD_W,
    parameter int unsigned SB_CNT_W  = CORE_SB_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    core_s2_operand_stage_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam logic [SB_CNT_W-1:0] SB_MAX = '1;

    logic [XLEN-1:0]      r_rf [NUM_REGS];
    s2_operands_t         r_out;
    logic                 r_out_valid;
    logic [PAYLOAD_W-1:0] r_payload;

    logic [SB_CNT_W-1:0]  w_rs1_cnt, w_rs2_cnt, w_rd_cnt;
    logic                 w_rs1_rdy, w_rs2_rdy;
    logic [XLEN-1:0]      w_rs1_val, w_rs2_val;
    logic                 w_struct_haz, w_ops_ready, w_in_ready, w_fire;
    logic                 w_wb_wr, w_flush_dec;

    // Returns {ready, value}; a lone pending write may be satisfied by writeback or bypass.
    function automatic logic [XLEN:0] resolve(
        input logic [IDX_W-1:0]         src,
        input logic [SB_CNT_W-1:0]      cnt,
        input logic [XLEN-1:0]          rf_val,
        input logic                     wb_hit,
        input logic [IDX_W-1:0]         wb_idx,
        input logic [XLEN-1:0]          wb_data,
        input logic [NUM_FWD-1:0]       fwd_valid,
        input logic [NUM_FWD*IDX_W-1:0] fwd_idx,
        input logic [NUM_FWD*XLEN-1:0]  fwd_data
    );
        logic            rdy;
        logic [XLEN-1:0] val;
        rdy = 1'b0;
        val = '0;
        if (src == '0) begin
            rdy = 1'b1;
        end else if (cnt == '0) begin
            rdy = 1'b1;
            val = rf_val;
        end else if (cnt == SB_CNT_W'(1)) begin
            if (wb_hit && (wb_idx == src)) begin
                rdy = 1'b1;
                val = wb_data;
            end else begin
                for (int i = 0; i < NUM_FWD; i++) begin
                    if (!rdy && fwd_valid[i] && (fwd_idx[i*IDX_W +: IDX_W] == src)) begin
                        rdy = 1'b1;
                        val = fwd_data[i*XLEN +: XLEN];
                    end
                end
            end
        end
        return {rdy, val};
    endfunction

    assign {w_rs1_rdy, w_rs1_val} = resolve(bus.in_rs1_idx, w_rs1_cnt, r_rf[bus.in_rs1_idx],
                                            bus.wb_valid & bus.wb_we, bus.wb_idx, bus.wb_data,
                                            bus.fwd_valid, bus.fwd_idx, bus.fwd_data);
    assign {w_rs2_rdy, w_rs2_val} = resolve(bus.in_rs2_idx, w_rs2_cnt, r_rf[bus.in_rs2_idx],
                                            bus.wb_valid & bus.wb_we, bus.wb_idx, bus.wb_data,
                                            bus.fwd_valid, bus.fwd_idx, bus.fwd_data);

    assign w_struct_haz = bus.in_rd_we && (bus.in_rd_idx != '0) && (w_rd_cnt == SB_MAX);
    assign w_ops_ready  = w_rs1_rdy && w_rs2_rdy && !w_struct_haz;
    assign w_in_ready   = w_ops_ready && !bus.flush && (!r_out_valid || bus.out_ready);
    assign w_fire       = bus.in_valid && w_in_ready;
    assign w_wb_wr      = bus.wb_valid && bus.wb_we && (bus.wb_idx != '0);
    assign w_flush_dec  = bus.flush && r_out_valid && r_out.rd_we;

    core_s2_operand_stage_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .SB_CNT_W (SB_CNT_W),
        .IDX_W    (IDX_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc_en   (w_fire && bus.in_rd_we),
        .i_inc_idx  (bus.in_rd_idx),
        .i_dec_en   (bus.wb_valid),
        .i_dec_idx  (bus.wb_idx),
        .i_fdec_en  (w_flush_dec),
        .i_fdec_idx (r_out.rd_idx),
        .i_rs1_idx  (bus.in_rs1_idx),
        .i_rs2_idx  (bus.in_rs2_idx),
        .i_rd_idx   (bus.in_rd_idx),
        .o_rs1_cnt  (w_rs1_cnt),
        .o_rs2_cnt  (w_rs2_cnt),
        .o_rd_cnt   (w_rd_cnt),
        .o_busy     (bus.sb_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_payload   <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_fire) begin
            r_out_valid   <= 1'b1;
            r_out.rs1_val <= w_rs1_val;
            r_out.rs2_val <= w_rs2_val;
            r_out.rd_idx  <= bus.in_rd_idx;
            r_out.rd_we   <= bus.in_rd_we;
            r_payload     <= bus.in_payload;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_rf[r] <= '0;
            end
        end else if (w_wb_wr) begin
            r_rf[bus.wb_idx] <= bus.wb_data;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_rs1_val = r_out.rs1_val;
    assign bus.out_rs2_val = r_out.rs2_val;
    assign bus.out_rd_idx  = r_out.rd_idx;
    assign bus.out_rd_we   = r_out.rd_we;
    assign bus.out_payload = r_payload;

endmodule

// File: tb/tb_core_s2_operand_stage.sv
// Directed bench for core_s2_operand_stage: vector table plus multi-cycle hazard sequences.
module tb_core_s2_operand_stage;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    core_s2_operand_stage_if bus ();

    core_s2_operand_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [63:0] payload;
        logic [1:0]  fv;
        logic [9:0]  fidx;
        logic [63:0] fdata;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic        e_busy;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_rs1_idx = '0;
        bus.in_rs2_idx = '0;
        bus.in_rd_idx  = '0;
        bus.in_rd_we   = 1'b0;
        bus.in_payload = '0;
        bus.out_ready  = 1'b1;
        bus.fwd_valid  = '0;
        bus.fwd_idx    = '0;
        bus.fwd_data   = '0;
        bus.wb_valid   = 1'b0;
        bus.wb_we      = 1'b0;
        bus.wb_idx     = '0;
        bus.wb_data    = '0;
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic rd_we, input logic [63:0] payload);
        bus.in_rs1_idx = rs1;
        bus.in_rs2_idx = rs2;
        bus.in_rd_idx  = rd;
        bus.in_rd_we   = rd_we;
        bus.in_payload = payload;
    endtask

    task automatic fire_now(input string name);
        bus.in_valid = 1'b1;
        #1;
        chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rd_we, input string name);
        set_in(rs1, rs2, rd, rd_we, 64'h0);
        fire_now(name);
    endtask

    task automatic wb(input logic [4:0] idx, input logic we, input logic [31:0] data);
        bus.wb_valid = 1'b1;
        bus.wb_we    = we;
        bus.wb_idx   = idx;
        bus.wb_data  = data;
        tick();
        bus.wb_valid = 1'b0;
        bus.wb_we    = 1'b0;
    endtask

    task automatic read2(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] e1,
                         input logic [31:0] e2, input string name);
        issue(rs1, rs2, 5'd0, 1'b0, name);
        chk({name, "_rs1"}, 64'(bus.out_rs1_val), 64'(e1));
        chk({name, "_rs2"}, 64'(bus.out_rs2_val), 64'(e2));
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        idle();

        vecs[0] = '{5'd1, 5'd2, 5'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 2'b00, 10'd0, 64'd0,
                    32'h1111_1111, 32'h2222_2222, 1'b0};
        vecs[1] = '{5'd0, 5'd5, 5'd0, 1'b0, 64'hFFFF_0000_FFFF_0000, 2'b00, 10'd0, 64'd0,
                    32'h0, 32'h5555_5555, 1'b0};
        vecs[2] = '{5'd2, 5'd2, 5'd0, 1'b0, 64'h0000_0000_0000_0002, 2'b01, {5'd0, 5'd2},
                    {32'h0, 32'hAAAA_AAAA}, 32'h2222_2222, 32'h2222_2222, 1'b0};
        vecs[3] = '{5'd5, 5'd1, 5'd6, 1'b0, 64'h1357_9BDF_2468_ACE0, 2'b11, {5'd1, 5'd5},
                    {32'hBBBB_BBBB, 32'hCCCC_CCCC}, 32'h5555_5555, 32'h1111_1111, 1'b0};
        vecs[4] = '{5'd7, 5'd0, 5'd0, 1'b1, 64'h0000_0000_0000_0004, 2'b00, 10'd0, 64'd0,
                    32'h0, 32'h0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sb_busy", 64'(bus.sb_busy), 64'd0);
        chk("rst_out_payload", bus.out_payload, 64'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Preload x1, x2, x5
        issue(5'd0, 5'd0, 5'd1, 1'b1, "ld1");
        chk("ld1_busy", 64'(bus.sb_busy), 64'd1);
        wb(5'd1, 1'b1, 32'h1111_1111);
        issue(5'd0, 5'd0, 5'd2, 1'b1, "ld2");
        wb(5'd2, 1'b1, 32'h2222_2222);
        issue(5'd0, 5'd0, 5'd5, 1'b1, "ld5");
        wb(5'd5, 1'b1, 32'h5555_5555);
        chk("ld_busy_clear", 64'(bus.sb_busy), 64'd0);

        // Vector table: idle scoreboard, so bypass data must be ignored
        for (int v = 0; v < 5; v++) begin
            set_in(vecs[v].rs1, vecs[v].rs2, vecs[v].rd, vecs[v].rd_we, vecs[v].payload);
            bus.fwd_valid = vecs[v].fv;
            bus.fwd_idx   = vecs[v].fidx;
            bus.fwd_data  = vecs[v].fdata;
            fire_now($sformatf("vec%0d", v));
            bus.fwd_valid = '0;
            chk($sformatf("vec%0d_out_valid", v), 64'(bus.out_valid), 64'd1);
            chk($sformatf("vec%0d_rs1", v), 64'(bus.out_rs1_val), 64'(vecs[v].e_rs1));
            chk($sformatf("vec%0d_rs2", v), 64'(bus.out_rs2_val), 64'(vecs[v].e_rs2));
            chk($sformatf("vec%0d_payload", v), bus.out_payload, vecs[v].payload);
            chk($sformatf("vec%0d_rd_idx", v), 64'(bus.out_rd_idx), 64'(vecs[v].rd));
            chk($sformatf("vec%0d_rd_we", v), 64'(bus.out_rd_we), 64'(vecs[v].rd_we));
            chk($sformatf("vec%0d_busy", v), 64'(bus.sb_busy), 64'(vecs[v].e_busy));
        end

        // Back-to-back dependency on x3
        issue(5'd0, 5'd0, 5'd3, 1'b1, "dep_i1");
        chk("dep_busy", 64'(bus.sb_busy), 64'd1);
        set_in(5'd3, 5'd0, 5'd0, 1'b0, 64'h0);
        bus.in_valid = 1'b1;
        #1;
        chk("dep_stall", 64'(bus.in_ready), 64'd0);
        tick();
        chk("dep_stall_out_valid", 64'(bus.out_valid), 64'd0);
        bus.fwd_valid = 2'b10;
        bus.fwd_idx   = {5'd3, 5'd0};
        bus.fwd_data  = {32'hDEAD_BEEF, 32'h0};
        fire_now("dep_i2");
        chk("dep_fwd1_rs1", 64'(bus.out_rs1_val), 64'hDEAD_BEEF);
        set_in(5'd0, 5'd3, 5'd0, 1'b0, 64'h0);
        bus.fwd_valid = 2'b11;
        bus.fwd_idx   = {5'd3, 5'd3};
        bus.fwd_data  = {32'h0BAD_F00D, 32'hC0FF_EE00};
        fire_now("dep_i3");
        chk("dep_fwd_prio_rs2", 64'(bus.out_rs2_val), 64'hC0FF_EE00);
        bus.fwd_valid = '0;
        wb(5'd3, 1'b1, 32'h3333_3333);
        chk("dep_busy_clear", 64'(bus.sb_busy), 64'd0);
        read2(5'd3, 5'd0, 32'h3333_3333, 32'h0, "dep_rd3");

        // Same-cycle writeback of x7
        issue(5'd0, 5'd0, 5'd7, 1'b1, "swb_i1");
        set_in(5'd0, 5'd7, 5'd0, 1'b0, 64'h0);
        bus.wb_valid = 1'b1;
        bus.wb_we    = 1'b1;
        bus.wb_idx   = 5'd7;
        bus.wb_data  = 32'h0000_1234;
        fire_now("swb_i2");
        bus.wb_valid = 1'b0;
        bus.wb_we    = 1'b0;
        chk("swb_rs2", 64'(bus.out_rs2_val), 64'h1234);
        chk("swb_busy", 64'(bus.sb_busy), 64'd0);
        read2(5'd0, 5'd7, 32'h0, 32'h0000_1234, "swb_rd7");

        // Double writer of x4
        issue(5'd0, 5'd0, 5'd4, 1'b1, "dw_i1");
        issue(5'd0, 5'd0, 5'd4, 1'b1, "dw_i2");
        set_in(5'd4, 5'd0, 5'd0, 1'b0, 64'h0);
        bus.fwd_valid = 2'b01;
        bus.fwd_idx   = {5'd0, 5'd4};
        bus.fwd_data  = {32'h0, 32'h0000_4444};
        bus.in_valid  = 1'b1;
        #1;
        chk("dw_stall", 64'(bus.in_ready), 64'd0);
        bus.wb_valid = 1'b1;
        bus.wb_we    = 1'b1;
        bus.wb_idx   = 5'd4;
        bus.wb_data  = 32'h0000_4040;
        #1;
        chk("dw_stall_wb", 64'(bus.in_ready), 64'd0);
        tick();
        bus.wb_valid = 1'b0;
        bus.wb_we    = 1'b0;
        fire_now("dw_rd");
        chk("dw_rs1", 64'(bus.out_rs1_val), 64'h4444);
        bus.fwd_valid = '0;
        wb(5'd4, 1'b1, 32'h0000_4444);
        chk("dw_busy_clear", 64'(bus.sb_busy), 64'd0);

        // Backpressure then flush of x9 writer
        drain();
        bus.out_ready = 1'b0;
        set_in(5'd1, 5'd2, 5'd9, 1'b1, 64'hCAFE_F00D_0000_0009);
        fire_now("bp_i1");
        set_in(5'd0, 5'd0, 5'd0, 1'b0, 64'h1);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", k), 64'(bus.in_ready), 64'd0);
            tick();
            chk($sformatf("bp%0d_out_valid", k), 64'(bus.out_valid), 64'd1);
            chk($sformatf("bp%0d_payload", k), bus.out_payload, 64'hCAFE_F00D_0000_0009);
            chk($sformatf("bp%0d_rd_idx", k), 64'(bus.out_rd_idx), 64'd9);
            chk($sformatf("bp%0d_rs1", k), 64'(bus.out_rs1_val), 64'h1111_1111);
        end
        chk("bp_busy", 64'(bus.sb_busy), 64'd1);
        bus.flush = 1'b1;
        #1;
        chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_busy", 64'(bus.sb_busy), 64'd0);
        bus.out_ready = 1'b1;

        // Saturation of x2 counter, killed writebacks, x0 writeback ignored
        drain();
        issue(5'd0, 5'd0, 5'd2, 1'b1, "sat_i1");
        issue(5'd0, 5'd0, 5'd2, 1'b1, "sat_i2");
        issue(5'd0, 5'd0, 5'd2, 1'b1, "sat_i3");
        set_in(5'd0, 5'd0, 5'd2, 1'b1, 64'h0);
        bus.in_valid = 1'b1;
        #1;
        chk("sat_stall", 64'(bus.in_ready), 64'd0);
        bus.wb_valid = 1'b1;
        bus.wb_we    = 1'b0;
        bus.wb_idx   = 5'd2;
        #1;
        chk("sat_stall_wb", 64'(bus.in_ready), 64'd0);
        tick();
        bus.wb_valid = 1'b0;
        fire_now("sat_i4");
        for (int k = 0; k < 3; k++) begin
            wb(5'd2, 1'b0, 32'hFFFF_FFFF);
        end
        chk("sat_busy_clear", 64'(bus.sb_busy), 64'd0);
        read2(5'd2, 5'd0, 32'h2222_2222, 32'h0, "sat_rd2");
        wb(5'd0, 1'b1, 32'hFFFF_FFFF);
        read2(5'd0, 5'd0, 32'h0, 32'h0, "x0_rd");

        // Reset mid-stream with a held output
        drain();
        bus.out_ready = 1'b0;
        issue(5'd5, 5'd0, 5'd5, 1'b1, "rst_i1");
        chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
        chk("rst_pre_busy", 64'(bus.sb_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_busy", 64'(bus.sb_busy), 64'd0);
        chk("rst_mid_rd_we", 64'(bus.out_rd_we), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        read2(5'd5, 5'd0, 32'h0, 32'h0, "rst_rd5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
